// File: rtl/cplx_pkg.sv
// Shared constants and sizing helpers for the complex-stream separator.
package cplx_pkg;

    localparam int unsigned MAX_DEPTH = 256;

    function automatic int unsigned clog2(input int unsigned value);
        int unsigned result;
        result = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((32'd1 << i) < value) result = i + 1;
        end
        return result;
    endfunction

    // Occupancy counters need one extra bit to represent "full".
    function automatic int unsigned lvl_w(input int unsigned depth);
        return clog2(depth) + 1;
    endfunction

    localparam int unsigned DEF_DEPTH = 4;
    localparam int unsigned DEF_LVL_W = lvl_w(DEF_DEPTH);

endpackage

// File: rtl/axis_sync_fifo.sv
// Circular-buffer FIFO with a registered head; level counts the head plus buffered entries.
module axis_sync_fifo
    import cplx_pkg::*;
#(
    parameter int unsigned DW    = 9,
    parameter int unsigned DEPTH = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [DW-1:0]           wr_data,
    input  logic                    wr_en,
    output logic [DW-1:0]           rd_data,
    output logic                    rd_valid,
    input  logic                    rd_ready,
    output logic [clog2(DEPTH):0]   level
);
    localparam int unsigned AW = clog2(DEPTH);

    logic [DW-1:0] mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [AW:0]   cnt_q, cnt_d;
    logic [DW-1:0] head_q, head_d;
    logic          head_vld_q, head_vld_d;
    logic          pop, head_free, mem_rd, mem_wr, bypass;

    // The head is only ever empty when the buffer is empty, so an empty lane
    // loads a fresh beat straight into the head and shows it next cycle.
    always_comb begin
        pop        = head_vld_q & rd_ready;
        head_free  = ~head_vld_q | pop;
        mem_rd     = head_free & (cnt_q != '0);
        bypass     = head_free & (cnt_q == '0) & wr_en;
        mem_wr     = wr_en & ~bypass;
        head_d     = head_q;
        head_vld_d = head_vld_q & ~pop;
        if (mem_rd) begin
            head_d     = mem_q[rd_ptr_q];
            head_vld_d = 1'b1;
        end else if (bypass) begin
            head_d     = wr_data;
            head_vld_d = 1'b1;
        end
        cnt_d = cnt_q;
        if (mem_wr && !mem_rd) begin
            cnt_d = cnt_q + 1'b1;
        end else if (!mem_wr && mem_rd) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            cnt_q      <= '0;
            head_q     <= '0;
            head_vld_q <= 1'b0;
        end else begin
            if (mem_wr) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (mem_rd) rd_ptr_q <= rd_ptr_q + 1'b1;
            cnt_q      <= cnt_d;
            head_q     <= head_d;
            head_vld_q <= head_vld_d;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_wr) mem_q[wr_ptr_q] <= wr_data;
    end

    assign rd_data  = head_q;
    assign rd_valid = head_vld_q;
    assign level    = cnt_q + {{AW{1'b0}}, head_vld_q};

endmodule

// File: rtl/cplx_sep_axis.sv
// Splits an interleaved Q:I AXI-Stream into independent I and Q streams,
// each buffered by its own FIFO so the lanes can drain at different rates.
module cplx_sep_axis
    import cplx_pkg::*;
#(
    parameter int unsigned W          = 8,
    parameter int unsigned DEPTH      = 4,
    parameter int unsigned SWAP_IQ    = 0,
    parameter int unsigned OFFSET_BIN = 0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [2*W-1:0]          s_axis_data_tdata,
    input  logic                    s_axis_data_tvalid,
    input  logic                    s_axis_data_tlast,
    output logic                    s_axis_data_tready,
    output logic [W-1:0]            m_axis_i_tdata,
    output logic                    m_axis_i_tvalid,
    output logic                    m_axis_i_tlast,
    input  logic                    m_axis_i_tready,
    output logic [W-1:0]            m_axis_q_tdata,
    output logic                    m_axis_q_tvalid,
    output logic                    m_axis_q_tlast,
    input  logic                    m_axis_q_tready,
    output logic [clog2(DEPTH):0]   i_level,
    output logic [clog2(DEPTH):0]   q_level
);
    localparam int unsigned      LVL_W    = lvl_w(DEPTH);
    localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(DEPTH);

    logic         rst_q;
    logic [W-1:0] raw_hi, raw_lo, i_comp, q_comp;
    logic         wr;
    logic [W:0]   i_rd, q_rd;

    always_ff @(posedge clk) begin
        rst_q <= rst;
    end

    always_comb begin
        raw_hi = s_axis_data_tdata[2*W-1:W];
        raw_lo = s_axis_data_tdata[W-1:0];
        i_comp = (SWAP_IQ != 0) ? raw_hi : raw_lo;
        q_comp = (SWAP_IQ != 0) ? raw_lo : raw_hi;
        if (OFFSET_BIN != 0) begin
            i_comp[W-1] = ~i_comp[W-1];
            q_comp[W-1] = ~q_comp[W-1];
        end
    end

    // Ready depends only on registered levels: a full lane blocks input even
    // while it is being drained, trading one bubble for no ready->ready path.
    assign s_axis_data_tready = ~rst_q & (i_level < FULL_LVL) & (q_level < FULL_LVL);
    assign wr                 = s_axis_data_tvalid & s_axis_data_tready;

    axis_sync_fifo #(
        .DW    (W + 1),
        .DEPTH (DEPTH)
    ) u_fifo_i (
        .clk      (clk),
        .rst      (rst),
        .wr_data  ({s_axis_data_tlast, i_comp}),
        .wr_en    (wr),
        .rd_data  (i_rd),
        .rd_valid (m_axis_i_tvalid),
        .rd_ready (m_axis_i_tready),
        .level    (i_level)
    );

    axis_sync_fifo #(
        .DW    (W + 1),
        .DEPTH (DEPTH)
    ) u_fifo_q (
        .clk      (clk),
        .rst      (rst),
        .wr_data  ({s_axis_data_tlast, q_comp}),
        .wr_en    (wr),
        .rd_data  (q_rd),
        .rd_valid (m_axis_q_tvalid),
        .rd_ready (m_axis_q_tready),
        .level    (q_level)
    );

    assign m_axis_i_tdata = i_rd[W-1:0];
    assign m_axis_i_tlast = i_rd[W];
    assign m_axis_q_tdata = q_rd[W-1:0];
    assign m_axis_q_tlast = q_rd[W];

endmodule

// File: tb/tb_cplx_sep_axis.sv
// Bench for cplx_sep_axis: vector table, lane backpressure, random scoreboard, reset mid-stream.
module tb_cplx_sep_axis;
    localparam int W     = 8;
    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [15:0] s_tdata = '0;
    logic        s_tlast = 1'b0, s_valid = 1'b0, s_ready;
    logic [7:0]  i_tdata, q_tdata;
    logic        i_tvalid, i_tlast, q_tvalid, q_tlast;
    logic        i_ready = 1'b0, q_ready = 1'b0;
    logic [2:0]  i_lvl, q_lvl;

    logic        sv_m = 1'b0, s_ready_m;
    logic [7:0]  i_tdata_m, q_tdata_m;
    logic        i_tvalid_m, i_tlast_m, q_tvalid_m, q_tlast_m;
    logic [2:0]  i_lvl_m, q_lvl_m;

    cplx_sep_axis #(.W(W), .DEPTH(DEPTH), .SWAP_IQ(0), .OFFSET_BIN(0)) dut (
        .clk (clk), .rst (rst),
        .s_axis_data_tdata (s_tdata), .s_axis_data_tvalid (s_valid),
        .s_axis_data_tlast (s_tlast), .s_axis_data_tready (s_ready),
        .m_axis_i_tdata (i_tdata), .m_axis_i_tvalid (i_tvalid),
        .m_axis_i_tlast (i_tlast), .m_axis_i_tready (i_ready),
        .m_axis_q_tdata (q_tdata), .m_axis_q_tvalid (q_tvalid),
        .m_axis_q_tlast (q_tlast), .m_axis_q_tready (q_ready),
        .i_level (i_lvl), .q_level (q_lvl)
    );

    cplx_sep_axis #(.W(W), .DEPTH(DEPTH), .SWAP_IQ(1), .OFFSET_BIN(1)) dut_m (
        .clk (clk), .rst (rst),
        .s_axis_data_tdata (s_tdata), .s_axis_data_tvalid (sv_m),
        .s_axis_data_tlast (s_tlast), .s_axis_data_tready (s_ready_m),
        .m_axis_i_tdata (i_tdata_m), .m_axis_i_tvalid (i_tvalid_m),
        .m_axis_i_tlast (i_tlast_m), .m_axis_i_tready (1'b1),
        .m_axis_q_tdata (q_tdata_m), .m_axis_q_tvalid (q_tvalid_m),
        .m_axis_q_tlast (q_tlast_m), .m_axis_q_tready (1'b1),
        .i_level (i_lvl_m), .q_level (q_lvl_m)
    );

    int n_tests = 0, n_fail = 0;
    int n_in = 0, n_i_out = 0, n_q_out = 0;
    logic [8:0] exp_i[$], exp_q[$];

    typedef struct {
        logic        mode;
        logic [15:0] din;
        logic        last;
        logic [7:0]  ei;
        logic [7:0]  eq;
    } vec_t;
    vec_t vecs[6];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock of the default DUT against a queue-per-lane model: a beat is taken
    // when both lanes hold fewer than DEPTH beats, and each lane shows its oldest beat.
    task automatic step(input logic v, input logic [15:0] d, input logic l,
                        input logic ir, input logic qr, output logic acc);
        logic       hs, pi, pq, hold_i, hold_q;
        logic [8:0] held_i, held_q;
        hs = v && (exp_i.size() < DEPTH) && (exp_q.size() < DEPTH);
        pi = (exp_i.size() > 0) && ir;
        pq = (exp_q.size() > 0) && qr;
        hold_i = (exp_i.size() > 0) && !ir;
        hold_q = (exp_q.size() > 0) && !qr;
        held_i = {i_tlast, i_tdata};
        held_q = {q_tlast, q_tdata};
        s_valid = v; s_tdata = d; s_tlast = l; i_ready = ir; q_ready = qr;
        if (pi) begin void'(exp_i.pop_front()); n_i_out++; end
        if (pq) begin void'(exp_q.pop_front()); n_q_out++; end
        if (hs) begin
            exp_i.push_back({l, d[7:0]});
            exp_q.push_back({l, d[15:8]});
            n_in++;
        end
        tick();
        s_valid = 1'b0;
        chk("i_level", 32'(i_lvl), 32'(exp_i.size()));
        chk("q_level", 32'(q_lvl), 32'(exp_q.size()));
        chk("s_tready", 32'(s_ready), 32'((exp_i.size() < DEPTH) && (exp_q.size() < DEPTH)));
        chk("i_tvalid", 32'(i_tvalid), 32'(exp_i.size() > 0));
        chk("q_tvalid", 32'(q_tvalid), 32'(exp_q.size() > 0));
        if (exp_i.size() > 0) chk("i_beat", 32'({i_tlast, i_tdata}), 32'(exp_i[0]));
        if (exp_q.size() > 0) chk("q_beat", 32'({q_tlast, q_tdata}), 32'(exp_q[0]));
        if (hold_i) chk("i_hold", 32'({i_tlast, i_tdata}), 32'(held_i));
        if (hold_q) chk("q_hold", 32'({q_tlast, q_tdata}), 32'(held_q));
        acc = hs;
    endtask

    initial begin
        int          idx, q0;
        logic        acc;
        logic [15:0] d;

        vecs[0] = '{1'b0, 16'hA53C, 1'b1, 8'h3C, 8'hA5};
        vecs[1] = '{1'b1, 16'h8000, 1'b0, 8'h00, 8'h80};
        vecs[2] = '{1'b1, 16'hFF7F, 1'b1, 8'h7F, 8'hFF};
        vecs[3] = '{1'b0, 16'h1234, 1'b0, 8'h34, 8'h12};
        vecs[4] = '{1'b1, 16'h1234, 1'b1, 8'h92, 8'hB4};
        vecs[5] = '{1'b0, 16'hFFFF, 1'b0, 8'hFF, 8'hFF};

        // Reset state
        rst = 1'b1;
        tick(); tick();
        chk("rst_i_level", 32'(i_lvl), 0);
        chk("rst_q_level", 32'(q_lvl), 0);
        chk("rst_tvalid", 32'({i_tvalid, q_tvalid, i_tvalid_m, q_tvalid_m}), 0);
        chk("rst_tdata", 32'({i_tdata, q_tdata}), 0);
        chk("rst_tlast", 32'({i_tlast, q_tlast}), 0);
        chk("rst_tready", 32'({s_ready, s_ready_m}), 0);
        chk("rst_m_level", 32'({i_lvl_m, q_lvl_m}), 0);
        rst = 1'b0;
        tick();
        chk("tready_after_rst", 32'({s_ready, s_ready_m}), 32'h3);

        // Vector table: one beat each, both consumers always ready
        i_ready = 1'b1; q_ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            s_tdata = vecs[k].din;
            s_tlast = vecs[k].last;
            if (vecs[k].mode) sv_m = 1'b1;
            else s_valid = 1'b1;
            tick();
            s_valid = 1'b0; sv_m = 1'b0;
            if (vecs[k].mode) begin
                chk("vec_m_valid", 32'({i_tvalid_m, q_tvalid_m}), 32'h3);
                chk("vec_m_i", 32'({i_tlast_m, i_tdata_m}), 32'({vecs[k].last, vecs[k].ei}));
                chk("vec_m_q", 32'({q_tlast_m, q_tdata_m}), 32'({vecs[k].last, vecs[k].eq}));
            end else begin
                chk("vec_valid", 32'({i_tvalid, q_tvalid}), 32'h3);
                chk("vec_i", 32'({i_tlast, i_tdata}), 32'({vecs[k].last, vecs[k].ei}));
                chk("vec_q", 32'({q_tlast, q_tdata}), 32'({vecs[k].last, vecs[k].eq}));
            end
            tick();
            chk("vec_one_cycle", 32'({i_tvalid, q_tvalid, i_tvalid_m, q_tvalid_m}), 0);
        end

        // Lane backpressure: I stalled, Q draining
        idx = 0;
        q0 = n_q_out;
        for (int c = 0; c < 12; c++) begin
            d = {8'(176 + idx), 8'(160 + idx)};
            step(idx < 6, d, idx == 5, 1'b0, 1'b1, acc);
            if (acc) idx++;
        end
        chk("bp_accepted", 32'(idx), 4);
        chk("bp_tready", 32'(s_ready), 0);
        chk("bp_i_level", 32'(i_lvl), 4);
        chk("bp_q_level", 32'(q_lvl), 0);
        chk("bp_q_emitted", 32'(n_q_out - q0), 4);
        for (int c = 0; c < 30 && !(idx == 6 && exp_i.size() == 0 && exp_q.size() == 0); c++) begin
            d = {8'(176 + idx), 8'(160 + idx)};
            step(idx < 6, d, idx == 5, 1'b1, 1'b1, acc);
            if (acc) idx++;
        end
        chk("bp_all_accepted", 32'(idx), 6);
        chk("bp_drained", 32'(exp_i.size() + exp_q.size()), 0);
        chk("bp_q_total", 32'(n_q_out - q0), 6);

        // Random stress
        idx = 0;
        for (int c = 0; c < 20000 && idx < 1000; c++) begin
            d = 16'($urandom);
            step($urandom_range(3) != 0, d, $urandom_range(7) == 0,
                 $urandom_range(9) < 6, $urandom_range(9) < 6, acc);
            if (acc) idx++;
        end
        for (int c = 0; c < 50 && (exp_i.size() + exp_q.size()) != 0; c++) begin
            step(1'b0, 16'h0, 1'b0, 1'b1, 1'b1, acc);
        end
        chk("stress_accepted", 32'(idx), 1000);
        chk("stress_i_count", 32'(n_i_out), 32'(n_in));
        chk("stress_q_count", 32'(n_q_out), 32'(n_in));

        // Reset mid-stream with i_level=3, q_level=1
        for (int k = 0; k < 3; k++) begin
            d = {8'(192 + k), 8'(208 + k)};
            step(1'b1, d, 1'b0, 1'b0, 1'b1, acc);
        end
        chk("pre_rst_i_level", 32'(i_lvl), 3);
        chk("pre_rst_q_level", 32'(q_lvl), 1);
        rst = 1'b1;
        tick();
        exp_i.delete();
        exp_q.delete();
        chk("mid_rst_levels", 32'({i_lvl, q_lvl}), 0);
        chk("mid_rst_tvalid", 32'({i_tvalid, q_tvalid}), 0);
        chk("mid_rst_tready", 32'(s_ready), 0);
        rst = 1'b0;
        tick();
        chk("post_rst_tready", 32'(s_ready), 1);
        step(1'b1, 16'h1234, 1'b0, 1'b1, 1'b1, acc);
        chk("post_rst_i", 32'({i_tvalid, i_tdata}), 32'h134);
        chk("post_rst_q", 32'({q_tvalid, q_tdata}), 32'h112);
        step(1'b0, 16'h0, 1'b0, 1'b1, 1'b1, acc);
        chk("post_rst_empty", 32'({i_tvalid, q_tvalid}), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
